// File: rtl/shift_out_driver.sv
// Serial transmitter for a daisy-chained SIPO (74HC595-style) register string.
// Shifts a WIDTH-bit word MSB-first on a divided clock, pulses the latch, then signals done.
module shift_out_driver #(
  parameter int WIDTH   = 32,
  parameter int CLK_DIV = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             busy,
  output logic             done,
  output logic             pending_full,
  output logic             sr_clk_out,
  output logic             sr_data_out,
  output logic             latch_out,
  output logic             oe_n
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             oe_on_q, oe_on_d;
  logic             div_last;

  assign div_last = (div_q == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      div_q       <= '0;
      bit_q       <= '0;
      oe_on_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      oe_on_q     <= oe_on_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    div_d       = div_q;
    bit_d       = bit_q;
    oe_on_d     = oe_on_q;

    // Loads arriving mid-frame park in the pending buffer; last writer wins.
    if (load && (state_q == SHIFT_LO || state_q == SHIFT_HI || state_q == LATCH)) begin
      pend_d      = data_in;
      pend_full_d = 1'b1;
    end

    if (state_q == SHIFT_LO || state_q == SHIFT_HI || state_q == LATCH)
      div_d = div_last ? '0 : div_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        if (load) begin
          shift_d = data_in;
          bit_d   = BW'(WIDTH - 1);
          div_d   = '0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (div_last) begin
          if (bit_q != '0) begin
            bit_d   = bit_q - 1'b1;
            state_d = SHIFT_LO;
          end else begin
            state_d = LATCH;
          end
        end
      end
      LATCH: begin
        if (div_last) begin
          state_d = DONE;
          oe_on_d = 1'b1;
        end
      end
      DONE: begin
        pend_full_d = 1'b0;
        div_d       = '0;
        bit_d       = BW'(WIDTH - 1);
        if (load) begin
          shift_d = data_in;
          state_d = SHIFT_LO;
        end else if (pend_full_q) begin
          shift_d = pend_q;
          state_d = SHIFT_LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign pending_full = pend_full_q;
  assign sr_clk_out   = (state_q == SHIFT_HI);
  assign sr_data_out  = (state_q == SHIFT_LO || state_q == SHIFT_HI) ? shift_q[bit_q] : 1'b0;
  assign latch_out    = (state_q == LATCH);
  assign oe_n         = ~oe_on_q;

endmodule

// File: tb/tb_shift_out_driver.sv
// Bench for shift_out_driver: cycle-level reference model plus a 595-chain scoreboard.
module tb_shift_out_driver;

  localparam int W = 8;
  localparam int D = 2;
  localparam int F = 2 * W * D + D + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       load8 = 1'b0;
  logic [7:0] data8 = '0;
  logic busy8, done8, pf8, sclk8, sdat8, latch8, oen8;

  logic        load32 = 1'b0;
  logic [31:0] data32 = '0;
  logic busy32, done32, pf32, sclk32, sdat32, latch32, oen32;

  shift_out_driver #(.WIDTH(W), .CLK_DIV(D)) dut8 (
    .clk(clk), .reset(reset), .data_in(data8), .load(load8),
    .busy(busy8), .done(done8), .pending_full(pf8), .sr_clk_out(sclk8),
    .sr_data_out(sdat8), .latch_out(latch8), .oe_n(oen8)
  );

  shift_out_driver dut32 (
    .clk(clk), .reset(reset), .data_in(data32), .load(load32),
    .busy(busy32), .done(done32), .pending_full(pf32), .sr_clk_out(sclk32),
    .sr_data_out(sdat32), .latch_out(latch32), .oe_n(oen32)
  );

  int checks = 0;
  int failures = 0;
  int t = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Reference model: frame timing from the frame-length formula, words from the pending rules
  logic [7:0] exp_q[$];
  bit         m_active = 0, m_pv = 0, m_oe = 0;
  int         m_start = 0, m_end = 0;
  logic [7:0] m_word = '0, m_pend = '0;

  task automatic mstart(input logic [7:0] w);
    m_active = 1;
    m_start  = t + 1;
    m_end    = t + F;
    m_word   = w;
    exp_q.push_back(w);
  endtask

  task automatic model_upd(input bit ld, input logic [7:0] d);
    if (!m_active) begin
      if (ld) mstart(d);
    end else if (t == m_end) begin
      m_oe = 1;
      if (ld) mstart(d);
      else if (m_pv) mstart(m_pend);
      else m_active = 0;
      m_pv = 0;
    end else if (ld) begin
      m_pend = d;
      m_pv   = 1;
    end
  endtask

  task automatic step(input bit ld, input logic [7:0] d);
    int p;
    bit ed, ec, edat, el;
    @(negedge clk);
    ed = m_active && (t == m_end);
    ec = 0; edat = 0; el = 0;
    if (m_active) begin
      p = t - m_start;
      if (p < 2 * W * D) begin
        ec   = ((p / D) % 2) == 1;
        edat = m_word[W - 1 - p / (2 * D)];
      end else if (p < 2 * W * D + D) begin
        el = 1;
      end
    end
    chk("outputs", {busy8, done8, pf8, sclk8, sdat8, latch8, oen8},
        {m_active, ed, m_pv, ec, edat, el, !(m_oe || ed)});
    load8 = ld;
    data8 = d;
    model_upd(ld, d);
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  // Reset is held across a clock edge with load=1; that load must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    load8 = 1'b0;
    #1;
    chk("reset_outputs", {busy8, done8, pf8, sclk8, sdat8, latch8, oen8}, 7'b0000001);
    m_active = 0; m_pv = 0; m_oe = 0;
    exp_q.delete();
    load8 = 1'b1;
    data8 = 8'h55;
    @(posedge clk);
    #1;
    reset = 1'b0;
    load8 = 1'b0;
    t++;
  endtask

  // 595 chain model for dut8: shifts on sr_clk rise, latches on latch rise
  logic [7:0] sreg8 = '0, par8 = '0;
  int  rises8 = 0, latch_cnt8 = 0;
  bit  unstable8 = 0;
  logic prev_clk8 = 0, prev_dat8 = 0, prev_lat8 = 0;

  initial begin
    logic [7:0] w;
    forever begin
      @(negedge clk);
      if (!busy8) begin
        rises8 = 0; latch_cnt8 = 0; unstable8 = 0;
      end else begin
        if (sclk8 && !prev_clk8) begin
          rises8++;
          if (sdat8 !== prev_dat8) unstable8 = 1;
          sreg8 = {sreg8[6:0], sdat8};
        end
        if (latch8) latch_cnt8++;
        if (latch8 && !prev_lat8) par8 = sreg8;
        if (done8) begin
          if (exp_q.size() == 0) begin
            chk("frame_unexpected", 1, 0);
          end else begin
            w = exp_q.pop_front();
            chk("chain_word", par8, w);
          end
          chk("sr_clk_rises", rises8, W);
          chk("latch_cycles", latch_cnt8, D);
          chk("data_stable", unstable8, 0);
          rises8 = 0; latch_cnt8 = 0; unstable8 = 0;
        end
      end
      prev_clk8 = sclk8; prev_dat8 = sdat8; prev_lat8 = latch8;
    end
  end

  task automatic run32();
    logic [31:0] sreg, par;
    int busy_cnt, rises, last_rise, i;
    bit seen, bad_period;
    logic pclk, plat;
    sreg = '0; par = '0; busy_cnt = 0; rises = 0; last_rise = 0;
    seen = 0; bad_period = 0; pclk = 0; plat = 0;
    @(negedge clk);
    load32 = 1'b1;
    data32 = 32'hDEADBEEF;
    @(negedge clk);
    load32 = 1'b0;
    for (i = 0; i < 8000; i++) begin
      if (busy32) begin
        busy_cnt++;
        seen = 1;
      end else if (seen) begin
        break;
      end
      if (sclk32 && !pclk) begin
        if (rises > 0 && (i - last_rise) != 2 * 100) bad_period = 1;
        rises++;
        last_rise = i;
        sreg = {sreg[30:0], sdat32};
      end
      if (latch32 && !plat) par = sreg;
      pclk = sclk32;
      plat = latch32;
      @(negedge clk);
    end
    chk("w32_timeout", i < 8000, 1);
    chk("w32_busy_cycles", busy_cnt, 6501);
    chk("w32_chain_word", par, 32'hDEADBEEF);
    chk("w32_rises", rises, 32);
    chk("w32_period", bad_period, 0);
    chk("w32_oe_n", oen32, 0);
  endtask

  initial begin
    logic [31:0] r;
    #1;
    chk("reset_initial", {busy8, done8, pf8, sclk8, sdat8, latch8, oen8}, 7'b0000001);
    do_reset();
    idle(3);

    // single frame
    step(1'b1, 8'hA5);
    idle(40);

    // pending buffer overwrite: 0F then 11 then 3C; second frame sends 3C
    step(1'b1, 8'h0F);
    idle(4);
    step(1'b1, 8'h11);
    idle(4);
    step(1'b1, 8'h3C);
    idle(80);

    // load in DONE beats the pending word
    step(1'b1, 8'hC3);
    idle(4);
    step(1'b1, 8'h11);
    idle(29);
    step(1'b1, 8'h80);
    idle(45);

    // reset at bit 3 of FF, then a clean frame
    step(1'b1, 8'hFF);
    idle(17);
    do_reset();
    chk("abort_no_latch", par8, 8'h80);
    idle(2);
    step(1'b1, 8'h01);
    idle(40);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      step(($urandom_range(0, 11) == 0), r[7:0]);
    end
    idle(100);
    chk("queue_empty", exp_q.size(), 0);

    run32();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_out_driver.md
Name: shift_out_driver

Overview:
- Serial transmitter for an external daisy-chained serial-in/parallel-out register string (74HC595 style) that drives the board's LED/indicator outputs.
- It is the output-side counterpart of the board sensor reader, which uses parallel-in/serial-out registers.
- The CPU side presents a WIDTH-bit word with a one-cycle load strobe. The block shifts the word out MSB-first on a divided shift clock, pulses the storage latch, then reports done.
- A one-deep pending buffer accepts a new word while a frame is in flight.

Parameters:
- WIDTH, 32, bits per frame (number of chained register outputs); must be at least 1.
- CLK_DIV, 100, clk cycles per half-period of sr_clk_out; must be at least 1.

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  word to transmit; sampled only in a cycle where load=1.
- load  input  1  single-cycle request strobe.
- busy  output  1  high while a frame is in progress, including the DONE cycle.
- done  output  1  one-cycle pulse at the end of each frame.
- pending_full  output  1  pending buffer holds a word that is not yet started.
- sr_clk_out  output  1  shift clock to the chain; a rising edge shifts one bit in.
- sr_data_out  output  1  serial data to the chain.
- latch_out  output  1  storage-register clock; active high.
- oe_n  output  1  active-low output enable to the chain.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE; shift register, pending buffer and all counters clear.
  - Outputs: busy=0, done=0, pending_full=0, sr_clk_out=0, sr_data_out=0, latch_out=0, oe_n=1.
- States are IDLE, SHIFT_LO, SHIFT_HI, LATCH and DONE. A divider counter runs 0..CLK_DIV-1 and a bit counter runs WIDTH-1 down to 0.
- IDLE:
  - Outputs: busy=0, sr_clk_out=0, sr_data_out=0, latch_out=0.
  - If load=1, data_in is captured into the shift register and the next state is SHIFT_LO with bit index WIDTH-1.
- SHIFT_LO (CLK_DIV cycles):
  - Outputs: sr_clk_out=0, sr_data_out=shift[bit], busy=1.
  - Goes to SHIFT_HI.
- SHIFT_HI (CLK_DIV cycles):
  - Outputs: sr_clk_out=1; sr_data_out holds the same bit, so data is stable across the rising edge.
  - If bit>0: bit decrements and the next state is SHIFT_LO.
  - If bit=0: the next state is LATCH.
- LATCH (CLK_DIV cycles):
  - Outputs: sr_clk_out=0, sr_data_out=0, latch_out=1.
  - Goes to DONE.
- DONE (1 cycle):
  - Outputs: done=1, busy=1, latch_out=0. oe_n goes to 0 at this cycle and stays 0 until reset.
  - The next word is data_in if load=1 in this cycle, otherwise the pending word if pending_full=1. In either case pending_full clears and the next state is SHIFT_LO.
  - With no next word, the next state is IDLE.
- Timing:
  - busy rises the cycle after load is accepted.
  - A frame lasts 2*WIDTH*CLK_DIV + CLK_DIV + 1 cycles, from the first SHIFT_LO cycle through DONE inclusive. With the defaults this is 6501 cycles.
  - Back-to-back frames have no IDLE gap.
- Load while busy (SHIFT_LO/HI or LATCH):
  - data_in is written into the pending buffer and pending_full goes to 1 the next cycle.
  - A further load overwrites it (last writer wins). Only one word is ever pending.
  - The in-flight frame is never altered.
- The shift register is not modified during a frame. The bit is selected by index, so frame data is the value captured at start.
- Reset asserted mid-frame aborts immediately:
  - latch_out is never pulsed for the aborted frame.
  - oe_n returns to 1.
  - The pending word is discarded.
- load in the same cycle that reset deasserts is ignored, because reset has priority.

Test Plan:
- Single frame, WIDTH=8, CLK_DIV=2: load with data_in=8'hA5 in IDLE → busy from next cycle; sr_data_out sequence 1,0,1,0,0,1,0,1, each held 4 cycles; 8 sr_clk_out rising edges, each mid-bit; latch_out high for 2 cycles; done pulses exactly at cycle 35 after load; oe_n 1→0 at done.
- Bench-model 595 chain (defaults, WIDTH=32, CLK_DIV=100): send 32'hDEADBEEF → model parallel output equals 32'hDEADBEEF after latch; busy high 6501 cycles; sr_clk period 200 cycles.
- Pending buffer, WIDTH=8, CLK_DIV=2: load 8'h0F, then 8'h11 at cycle 5, then 8'h3C at cycle 10 → pending_full=1; second frame starts the cycle after the first done and transmits 8'h3C; no IDLE cycle between frames; exactly two done pulses.
- Load in DONE cycle: pending holds 8'h11 and load=1 with data_in=8'h80 in DONE → next frame transmits 8'h80; pending_full=0 afterwards.
- Reset mid-frame: assert reset at bit 3 of 8'hFF → same-cycle outputs all 0, oe_n=1, busy=0; no latch_out pulse; after release and a new load of 8'h01, a clean frame with correct timing.
- Load ignored cases: load with busy=0 right at reset release → stays IDLE; load=0 in DONE with pending empty → IDLE, busy=0 the following cycle.
